// File: rtl/modexp_arbiter_if.sv
// Purpose     : request/response channels of the two RSA requesters plus the engine operand/result bus.
// Latency     : none (wires only).
// Backpressure: valid/ready on both request and response channels; engine held by modexp_ready level.
`timescale 1ns/1ps
interface modexp_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_msg;
    logic [WIDTH-1:0] req0_exp;
    logic [WIDTH-1:0] req0_mod;
    logic             resp0_valid;
    logic             resp0_ready;
    logic [WIDTH-1:0] resp0_result;
    logic             resp0_err;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_msg;
    logic [WIDTH-1:0] req1_exp;
    logic [WIDTH-1:0] req1_mod;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp1_result;
    logic             resp1_err;

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] power;
    logic [WIDTH-1:0] denominator;
    logic             modexp_ready;
    logic [WIDTH-1:0] result;
    logic             modexp_done;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_msg, req0_exp, req0_mod, resp0_ready,
        output req0_ready, resp0_valid, resp0_result, resp0_err,
        input  req1_valid, req1_msg, req1_exp, req1_mod, resp1_ready,
        output req1_ready, resp1_valid, resp1_result, resp1_err,
        output base, e, power, denominator, modexp_ready,
        input  result, modexp_done
    );

    // Environment side: requesters and engine.
    modport master (
        output req0_valid, req0_msg, req0_exp, req0_mod, resp0_ready,
        input  req0_ready, resp0_valid, resp0_result, resp0_err,
        output req1_valid, req1_msg, req1_exp, req1_mod, resp1_ready,
        input  req1_ready, resp1_valid, resp1_result, resp1_err,
        input  base, e, power, denominator, modexp_ready,
        output result, modexp_done
    );
endinterface

// File: rtl/modexp_arbiter.sv
// Purpose     : round-robin arbiter sharing one modexp engine between encrypt (port 0) and decrypt (port 1).
// Latency     : engine latency + 1 cycle in + 1 cycle out; mod==0 jobs answer the cycle after accept.
// Backpressure: one job in flight; response held until respN_ready; losing requester waits with valid high.
// Option      : define MODEXP_TIMEOUT_EN to enable the RUN watchdog of TIMEOUT_CYCLES cycles.
`timescale 1ns/1ps
module modexp_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              i_clk,
    input  logic              i_reset,
    modexp_arbiter_if.slave   bus,
    output logic              o_busy,
    output logic              o_grant_id
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    state_t           r_state;
    logic             r_rr;          // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic             r_grant;
    logic             r_busy;
    logic             r_modexp_ready;
    logic             r_resp0_valid;
    logic             r_resp1_valid;
    logic             r_resp_err;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_power;
    logic [WIDTH-1:0] r_denom;
    logic [WIDTH-1:0] r_resp_result;

`ifdef MODEXP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
`endif

    logic             w_can_grant;
    logic             w_win;
    logic             w_accept;
    logic             w_resp_hs;
    logic [WIDTH-1:0] w_msg;
    logic [WIDTH-1:0] w_exp;
    logic [WIDTH-1:0] w_mod;

    // Arbitration: a grant needs IDLE and a fully retired engine (done low).
    always_comb begin
        w_can_grant = (r_state == S_IDLE) && !bus.modexp_done && !i_reset;
        w_win       = (bus.req0_valid && bus.req1_valid) ? r_rr : bus.req1_valid;
        w_accept    = w_can_grant && (bus.req0_valid || bus.req1_valid);
        w_msg       = w_win ? bus.req1_msg : bus.req0_msg;
        w_exp       = w_win ? bus.req1_exp : bus.req0_exp;
        w_mod       = w_win ? bus.req1_mod : bus.req0_mod;
        w_resp_hs   = (r_resp0_valid && bus.resp0_ready) || (r_resp1_valid && bus.resp1_ready);
    end

    assign bus.req0_ready   = w_can_grant && bus.req0_valid && !w_win;
    assign bus.req1_ready   = w_can_grant && bus.req1_valid &&  w_win;
    assign bus.resp0_valid  = r_resp0_valid;
    assign bus.resp1_valid  = r_resp1_valid;
    assign bus.resp0_result = r_resp_result;
    assign bus.resp1_result = r_resp_result;
    assign bus.resp0_err    = r_resp_err;
    assign bus.resp1_err    = r_resp_err;
    assign bus.base         = r_base;
    assign bus.e            = r_e;
    assign bus.power        = r_power;
    assign bus.denominator  = r_denom;
    assign bus.modexp_ready = r_modexp_ready;
    assign o_busy           = r_busy;
    assign o_grant_id       = r_grant;

    // Job FSM: IDLE -> RUN -> RESP -> IDLE, or IDLE -> RESP for a zero modulus.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_rr           <= 1'b0;
            r_grant        <= 1'b0;
            r_busy         <= 1'b0;
            r_modexp_ready <= 1'b0;
            r_resp0_valid  <= 1'b0;
            r_resp1_valid  <= 1'b0;
            r_resp_err     <= 1'b0;
            r_base         <= '0;
            r_e            <= '0;
            r_power        <= '0;
            r_denom        <= '0;
            r_resp_result  <= '0;
`ifdef MODEXP_TIMEOUT_EN
            r_cnt          <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_grant <= w_win;
                        r_rr    <= ~w_win;
                        r_busy  <= 1'b1;
                        if (w_mod == '0) begin
                            r_resp_result <= '0;
                            r_resp_err    <= 1'b1;
                            r_resp0_valid <= ~w_win;
                            r_resp1_valid <= w_win;
                            r_state       <= S_RESP;
                        end else begin
                            r_e            <= w_exp;
                            r_power        <= w_msg;
                            r_denom        <= w_mod;
                            r_base         <= WIDTH'(1);
                            r_modexp_ready <= 1'b1;
                            r_state        <= S_RUN;
`ifdef MODEXP_TIMEOUT_EN
                            r_cnt          <= '0;
`endif
                        end
                    end
                end
                S_RUN: begin
                    if (bus.modexp_done) begin
                        r_resp_result  <= bus.result;
                        r_resp_err     <= 1'b0;
                        r_modexp_ready <= 1'b0;
                        r_base         <= '0;
                        r_resp0_valid  <= ~r_grant;
                        r_resp1_valid  <= r_grant;
                        r_state        <= S_RESP;
                    end
`ifdef MODEXP_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_resp_result  <= '0;
                        r_resp_err     <= 1'b1;
                        r_modexp_ready <= 1'b0;
                        r_base         <= '0;
                        r_resp0_valid  <= ~r_grant;
                        r_resp1_valid  <= r_grant;
                        r_state        <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (w_resp_hs) begin
                        r_resp0_valid <= 1'b0;
                        r_resp1_valid <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_arbiter.sv
// Purpose     : self-checking bench for modexp_arbiter with a behavioural engine and a response scoreboard.
// Latency     : engine model asserts done ENG_LAT cycles after modexp_ready rises.
// Backpressure: requesters hold valid until ready; response ready stalled in one sequence.
`timescale 1ns/1ps
module tb_modexp_arbiter;
    localparam int W       = 32;
    localparam int ENG_LAT = 6;
    localparam int NV      = 9;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic grant_id;

    always #5 clk = ~clk;

    modexp_arbiter_if #(.WIDTH(W)) bus ();

    modexp_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .bus       (bus),
        .o_busy    (busy),
        .o_grant_id(grant_id)
    );

    typedef struct {
        int         port;
        logic [W-1:0] msg;
        logic [W-1:0] xp;
        logic [W-1:0] md;
        logic [W-1:0] res;
        logic       err;
    } vec_t;

    typedef struct {
        int         port;
        logic [W-1:0] res;
        logic       err;
    } sb_t;

    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rv_cycles[2] = '{0, 0};
    int   eng_starts = 0;
    int   eng_cnt = 0;
    logic eng_ready_q = 1'b0;
    bit   eng_hang = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, m, x, n);
        logic [63:0] acc;
        logic [63:0] p;
        if (n == '0) return '0;
        acc = 64'(b) % 64'(n);
        p   = 64'(m) % 64'(n);
        for (int i = 0; i < W; i++) begin
            if (x[i]) acc = (acc * p) % 64'(n);
            p = (p * p) % 64'(n);
        end
        return acc[W-1:0];
    endfunction

    // Engine model: counts while modexp_ready is high, holds done until modexp_ready drops.
    always @(posedge clk) begin
        eng_ready_q <= bus.modexp_ready;
        if (bus.modexp_ready && !eng_ready_q && !reset) eng_starts <= eng_starts + 1;
        if (reset || !bus.modexp_ready) begin
            eng_cnt         <= 0;
            bus.modexp_done <= 1'b0;
        end else if (!bus.modexp_done && !eng_hang) begin
            if (eng_cnt == ENG_LAT - 1) begin
                bus.modexp_done <= 1'b1;
                bus.result      <= ref_modexp(bus.base, bus.power, bus.e, bus.denominator);
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    task automatic mon_pop(input int p);
        sb_t          ent;
        logic [W-1:0] r;
        logic         er;
        r  = (p == 0) ? bus.resp0_result : bus.resp1_result;
        er = (p == 0) ? bus.resp0_err    : bus.resp1_err;
        check("resp_expected", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
            ent = sb.pop_front();
            check("resp_port",   W'(p),  W'(ent.port));
            check("resp_result", r,      ent.res);
            check("resp_err",    W'(er), W'(ent.err));
        end
    endtask

    // Response monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.resp0_valid) rv_cycles[0]++;
            if (bus.resp1_valid) rv_cycles[1]++;
            if (bus.resp0_valid && bus.resp0_ready) mon_pop(0);
            if (bus.resp1_valid && bus.resp1_ready) mon_pop(1);
        end
    end

    task automatic send(input int p, input logic [W-1:0] m, x, n);
        bit ok = 1'b0;
        @(posedge clk); #1;
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_msg = m; bus.req0_exp = x; bus.req0_mod = n;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_msg = m; bus.req1_exp = x; bus.req1_mod = n;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ((p == 0) ? bus.req0_ready : bus.req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (p == 0) begin
            bus.req0_valid = 1'b0; bus.req0_msg = ~m; bus.req0_exp = ~x; bus.req0_mod = ~n;
        end else begin
            bus.req1_valid = 1'b0; bus.req1_msg = ~m; bus.req1_exp = ~x; bus.req1_mod = ~n;
        end
        check($sformatf("accept_p%0d", p), W'(ok), W'(1));
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, W'(ok), W'(1));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t vecs[NV];
        vec_t v;
        int   starts0;
        int   rv_other0;
        int   rv0_snap;
        int   rv1_snap;
        int   cyc;
        bit   seen;
        bit   stable;
        bit   blocked;

        vecs[0] = '{0, 32'd11,         32'd13, 32'd53,         32'd52,  1'b0};
        vecs[1] = '{1, 32'd22,         32'd5,  32'd273,        32'd211, 1'b0};
        vecs[2] = '{0, 32'd31,         32'd6,  32'd273,        32'd64,  1'b0};
        vecs[3] = '{0, 32'd5,          32'd3,  32'd0,          32'd0,   1'b1};
        vecs[4] = '{1, 32'd7,          32'd0,  32'd13,         32'd1,   1'b0};
        vecs[5] = '{0, 32'd9,          32'd3,  32'd1,          32'd0,   1'b0};
        vecs[6] = '{1, 32'hFFFF_FFFF,  32'd2,  32'hFFFF_FFFB,  32'd16,  1'b0};
        vecs[7] = '{1, 32'd2,          32'd10, 32'd1000,       32'd24,  1'b0};
        vecs[8] = '{1, 32'd123,        32'd4,  32'd0,          32'd0,   1'b1};

        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_msg = '0; bus.req0_exp = '0; bus.req0_mod = 32'd7;
        bus.req1_valid = 1'b1; bus.req1_msg = '0; bus.req1_exp = '0; bus.req1_mod = 32'd7;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_base",     bus.base,               '0);
        check("rst_e",        bus.e,                  '0);
        check("rst_power",    bus.power,              '0);
        check("rst_denom",    bus.denominator,        '0);
        check("rst_mready",   W'(bus.modexp_ready),   '0);
        check("rst_busy",     W'(busy),               '0);
        check("rst_grant",    W'(grant_id),           '0);
        check("rst_rv0",      W'(bus.resp0_valid),    '0);
        check("rst_rv1",      W'(bus.resp1_valid),    '0);
        check("rst_result",   bus.resp0_result,       '0);
        check("rst_err",      W'(bus.resp1_err),      '0);
        check("rst_req0_rdy", W'(bus.req0_ready),     '0);
        check("rst_req1_rdy", W'(bus.req1_ready),     '0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        // Single-job vectors, one at a time.
        for (int i = 0; i < NV; i++) begin
            v         = vecs[i];
            starts0   = eng_starts;
            rv_other0 = rv_cycles[1 - v.port];
            sb.push_back('{v.port, v.res, v.err});
            send(v.port, v.msg, v.xp, v.md);
            if (!v.err) begin
                check($sformatf("v%0d_e", i),      bus.e,           v.xp);
                check($sformatf("v%0d_power", i),  bus.power,       v.msg);
                check($sformatf("v%0d_denom", i),  bus.denominator, v.md);
                check($sformatf("v%0d_base", i),   bus.base,        W'(1));
                check($sformatf("v%0d_mready", i), W'(bus.modexp_ready), W'(1));
            end else begin
                check($sformatf("v%0d_rej_valid", i),
                      W'((v.port == 0) ? bus.resp0_valid : bus.resp1_valid), W'(1));
                check($sformatf("v%0d_rej_mready", i), W'(bus.modexp_ready), W'(0));
            end
            check($sformatf("v%0d_grant", i), W'(grant_id), W'(v.port));
            check($sformatf("v%0d_busy", i),  W'(busy),     W'(1));
            wait_idle($sformatf("v%0d_idle", i));
            check($sformatf("v%0d_eng_starts", i), W'(eng_starts - starts0), W'(v.err ? 0 : 1));
            check($sformatf("v%0d_other_quiet", i), W'(rv_cycles[1 - v.port] - rv_other0), W'(0));
        end

        // Simultaneous requests after reset: p0 first, then the next tie goes to p1.
        pulse_reset();
        sb.push_back('{0, 32'd64,  1'b0});
        sb.push_back('{1, 32'd211, 1'b0});
        sb.push_back('{0, 32'd52,  1'b0});
        fork
            begin
                send(0, 32'd31, 32'd6, 32'd273);
                send(0, 32'd11, 32'd13, 32'd53);
            end
            send(1, 32'd22, 32'd5, 32'd273);
        join
        wait_idle("rr_idle");

        // Response stall on port 0 while port 1 waits.
        bus.resp0_ready = 1'b0;
        sb.push_back('{0, 32'd52,  1'b0});
        sb.push_back('{1, 32'd211, 1'b0});
        send(0, 32'd11, 32'd13, 32'd53);
        fork
            send(1, 32'd22, 32'd5, 32'd273);
            begin
                seen = 1'b0;
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (bus.resp0_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("stall_resp_seen", W'(seen), W'(1));
                stable  = 1'b1;
                blocked = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (!bus.resp0_valid || bus.resp0_result !== 32'd52 || bus.resp0_err !== 1'b0)
                        stable = 1'b0;
                    if (bus.req1_ready || bus.resp1_valid || grant_id !== 1'b0)
                        blocked = 1'b0;
                end
                check("stall_stable",    W'(stable),  W'(1));
                check("stall_req1_wait", W'(blocked), W'(1));
                @(posedge clk); #1 bus.resp0_ready = 1'b1;
            end
        join
        wait_idle("stall_idle");

        // Reset while the engine is running drops the job silently.
        send(1, 32'd22, 32'd5, 32'd273);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_mready", W'(bus.modexp_ready), '0);
        check("mid_rst_base",   bus.base,             '0);
        check("mid_rst_e",      bus.e,                '0);
        check("mid_rst_power",  bus.power,            '0);
        check("mid_rst_denom",  bus.denominator,      '0);
        check("mid_rst_busy",   W'(busy),             '0);
        check("mid_rst_grant",  W'(grant_id),         '0);
        check("mid_rst_result", bus.resp1_result,     '0);
        reset = 1'b0;
        rv0_snap = rv_cycles[0];
        rv1_snap = rv_cycles[1];
        repeat (20) @(negedge clk);
        check("mid_rst_no_resp", W'(rv_cycles[0] + rv_cycles[1] - rv0_snap - rv1_snap), W'(0));
        check("mid_rst_idle", W'(busy), W'(0));

`ifdef MODEXP_TIMEOUT_EN
        // Engine never finishes: watchdog answers with err after 16 RUN cycles.
        eng_hang = 1'b1;
        sb.push_back('{0, 32'd0, 1'b1});
        send(0, 32'd11, 32'd13, 32'd53);
        cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.resp0_valid) begin
                cyc = c;
                break;
            end
        end
        check("timeout_latency", W'(cyc), W'(17));
        wait_idle("timeout_idle");
        eng_hang = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
